// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and helper function
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_state_e;

  // Defaults shared by the receiver and transmitter
  localparam int DEF_NBITS    = 8;
  localparam int DEF_STP_BITS = 1;
  localparam int DEF_OS       = 16;
  localparam int DEF_CLK_DIV  = 10;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - serial input, config and valid/ready word output of the receiver
interface uart_rx_param_if
  import uart_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
);

  logic             rx;
  logic             parity_en;
  logic             parity_odd;
  logic             rx_ready;
  logic [NBITS-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             parity_err;
  logic             overrun_err;

  modport master (
    input  rx, parity_en, parity_odd, rx_ready,
    output rx_data, rx_valid, frame_err, parity_err, overrun_err
  );

  modport slave (
    output rx, parity_en, parity_odd, rx_ready,
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err
  );

endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running divider producing a one-clk oversample tick
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity, framing and overrun reporting
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int NBITS    = DEF_NBITS,
  parameter int STP_BITS = DEF_STP_BITS,
  parameter int OS       = DEF_OS,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_param_if.master u
);

  localparam int SW = clog2(OS) + 1;
  localparam int NW = clog2(NBITS) + 1;

  logic             rx_meta;
  logic             rx_s;
  logic             tick;
  uart_state_e      state;
  logic [SW-1:0]    s_cnt;
  logic [NW-1:0]    n;
  logic [NBITS-1:0] sr;
  logic             par;
  logic             pen_l;
  logic             podd_l;
  logic             ferr;
  logic             perr;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= u.rx;
      rx_s    <= rx_meta;
    end
  end

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      s_cnt         <= '0;
      n             <= '0;
      sr            <= '0;
      par           <= 1'b0;
      pen_l         <= 1'b0;
      podd_l        <= 1'b0;
      ferr          <= 1'b0;
      perr          <= 1'b0;
      u.rx_data     <= '0;
      u.rx_valid    <= 1'b0;
      u.frame_err   <= 1'b0;
      u.parity_err  <= 1'b0;
      u.overrun_err <= 1'b0;
    end else begin
      u.overrun_err <= 1'b0;
      if (u.rx_valid && u.rx_ready) begin
        u.rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            s_cnt <= '0;
            state <= START;
          end
        end

        START: begin
          if (tick) begin
            if (s_cnt == SW'(OS / 2 - 1)) begin
              if (!rx_s) begin
                s_cnt  <= '0;
                n      <= '0;
                par    <= 1'b0;
                ferr   <= 1'b0;
                perr   <= 1'b0;
                pen_l  <= u.parity_en;
                podd_l <= u.parity_odd;
                state  <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s_cnt == SW'(OS - 1)) begin
              s_cnt <= '0;
              sr    <= {rx_s, sr[NBITS-1:1]};
              par   <= par ^ rx_s;
              if (n == NW'(NBITS - 1)) begin
                n     <= '0;
                state <= pen_l ? PARITY : STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (tick) begin
            if (s_cnt == SW'(OS - 1)) begin
              s_cnt <= '0;
              perr  <= par ^ rx_s ^ podd_l;
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s_cnt == SW'(OS - 1)) begin
              s_cnt <= '0;
              if (!rx_s) begin
                ferr <= 1'b1;
              end
              if (n == NW'(STP_BITS - 1)) begin
                n     <= '0;
                state <= DONE;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // A held word that is not being taken this cycle wins over the new frame
          if (!u.rx_valid || u.rx_ready) begin
            u.rx_data    <= sr;
            u.frame_err  <= ferr;
            u.parity_err <= perr;
            u.rx_valid   <= 1'b1;
          end else begin
            u.overrun_err <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 5-bit/2-stop instances)
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS_T     = 16;
  localparam int CD_T     = 4;
  localparam int BIT_CLKS = OS_T * CD_T;

  typedef struct {
    logic [8:0] data;
    bit         ferr;
    bit         perr;
    bit         ovr;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.NBITS(8)) ifa ();
  uart_rx_param_if #(.NBITS(5)) ifb ();

  uart_rx_param #(.NBITS(8), .STP_BITS(1), .OS(OS_T), .CLK_DIV(CD_T)) dut_a (
    .clk   (clk),
    .reset (reset),
    .u     (ifa.master)
  );

  uart_rx_param #(.NBITS(5), .STP_BITS(2), .OS(OS_T), .CLK_DIV(CD_T)) dut_b (
    .clk   (clk),
    .reset (reset),
    .u     (ifb.master)
  );

  exp_t       qa[$];
  exp_t       qb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         pv[2];
  bit         pr[2];
  logic [8:0] held[2];
  logic [8:0] last_data[2];
  bit         last_fe[2];
  bit         last_pe[2];
  int         rises[2];
  int         ovr_seen[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t pop_q(input int k);
    if (k == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  task automatic cmp(input int k, input bit v, input bit ov, input logic [8:0] d,
                     input bit fe, input bit pe, input bit rdy);
    exp_t  e;
    string t;
    t = (k == 0) ? "a" : "b";
    if (v && !pv[k]) begin
      rises[k]++;
      if (qsize(k) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_spurious_valid: got data %0h with no frame expected", t, d);
      end else begin
        e = pop_q(k);
        check({t, "_kind_not_overrun"}, 32'(e.ovr), 32'(0));
        check({t, "_data"}, 32'(d), 32'(e.data));
        check({t, "_frame_err"}, 32'(fe), 32'(e.ferr));
        check({t, "_parity_err"}, 32'(pe), 32'(e.perr));
        held[k] = e.data;
      end
      last_data[k] = d;
      last_fe[k]   = fe;
      last_pe[k]   = pe;
    end else if (v && pv[k]) begin
      check({t, "_hold_data"}, 32'(d), 32'(held[k]));
    end
    if (pv[k] && pr[k]) begin
      check({t, "_valid_clear"}, 32'(v), 32'(0));
    end
    if (ov) begin
      ovr_seen[k]++;
      if (qsize(k) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_spurious_overrun: got pulse with no frame expected", t);
      end else begin
        e = pop_q(k);
        check({t, "_kind_overrun"}, 32'(e.ovr), 32'(1));
      end
    end
    pv[k] = v;
    pr[k] = rdy;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cmp(0, ifa.rx_valid, ifa.overrun_err, {1'b0, ifa.rx_data}, ifa.frame_err, ifa.parity_err, ifa.rx_ready);
      cmp(1, ifb.rx_valid, ifb.overrun_err, {4'b0, ifb.rx_data}, ifb.frame_err, ifb.parity_err, ifb.rx_ready);
    end else begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end
  end

  task automatic drive_rx(input int k, input bit lvl, input int clks);
    if (k == 0) ifa.rx = lvl;
    else        ifb.rx = lvl;
    repeat (clks) @(negedge clk);
  endtask

  // Model: the word is the low nb bits; parity is wrong when the received bit breaks even/odd count
  task automatic send(input int k, input logic [8:0] d, input int nb, input bit pen, input bit podd,
                      input bit pbit, input int nstop, input bit stop_lvl, input bit expect_ovr,
                      input int idle_clks);
    exp_t       e;
    logic [8:0] mask;
    mask   = 9'((1 << nb) - 1);
    e.data = d & mask;
    e.ferr = !stop_lvl;
    e.perr = pen ? (pbit != ((^e.data) ^ podd)) : 1'b0;
    e.ovr  = expect_ovr;
    if (k == 0) begin
      qa.push_back(e);
      ifa.parity_en  = pen;
      ifa.parity_odd = podd;
    end else begin
      qb.push_back(e);
      ifb.parity_en  = pen;
      ifb.parity_odd = podd;
    end
    drive_rx(k, 1'b0, BIT_CLKS);
    for (int i = 0; i < nb; i++) drive_rx(k, d[i], BIT_CLKS);
    if (pen) drive_rx(k, pbit, BIT_CLKS);
    for (int i = 0; i < nstop; i++) begin
      drive_rx(k, stop_lvl, BIT_CLKS - 16);
      drive_rx(k, 1'b1, 16);
    end
    if (idle_clks > 0) drive_rx(k, 1'b1, idle_clks);
  endtask

  task automatic reset_mid_data(input int k);
    drive_rx(k, 1'b0, BIT_CLKS);
    drive_rx(k, 1'b1, 3 * BIT_CLKS);
    reset = 1'b0;
    @(negedge clk);
    if (k == 0) begin
      check("a_rst_valid", 32'(ifa.rx_valid), 32'(0));
      check("a_rst_data", 32'(ifa.rx_data), 32'(0));
      check("a_rst_ferr", 32'(ifa.frame_err), 32'(0));
      check("a_rst_ovr", 32'(ifa.overrun_err), 32'(0));
    end else begin
      check("b_rst_valid", 32'(ifb.rx_valid), 32'(0));
      check("b_rst_data", 32'(ifb.rx_data), 32'(0));
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    drive_rx(k, 1'b1, 2 * BIT_CLKS);
  endtask

  initial begin
    int r0;
    ifa.rx = 1'b1; ifa.rx_ready = 1'b1; ifa.parity_en = 1'b0; ifa.parity_odd = 1'b0;
    ifb.rx = 1'b1; ifb.rx_ready = 1'b1; ifb.parity_en = 1'b0; ifb.parity_odd = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_a_valid", 32'(ifa.rx_valid), 32'(0));
    check("init_a_data", 32'(ifa.rx_data), 32'(0));
    check("init_a_ovr", 32'(ifa.overrun_err), 32'(0));
    check("init_b_valid", 32'(ifb.rx_valid), 32'(0));
    reset = 1'b1;
    repeat (10) @(negedge clk);

    send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_a5_data", 32'(last_data[0]), 32'h0A5);
    check("lit_a5_fe", 32'(last_fe[0]), 32'(0));
    check("lit_a5_pe", 32'(last_pe[0]), 32'(0));

    send(0, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_even_p1", 32'(last_pe[0]), 32'(0));
    send(0, 9'h007, 8, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_even_p0", 32'(last_pe[0]), 32'(1));
    send(0, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_odd_p1", 32'(last_pe[0]), 32'(1));
    send(0, 9'h007, 8, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_odd_p0", 32'(last_pe[0]), 32'(0));

    send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, BIT_CLKS);
    check("lit_3c_data", 32'(last_data[0]), 32'h03C);
    check("lit_3c_fe", 32'(last_fe[0]), 32'(1));
    send(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_11_data", 32'(last_data[0]), 32'h011);
    check("lit_11_fe", 32'(last_fe[0]), 32'(0));

    r0 = rises[0];
    drive_rx(0, 1'b0, 3 * CD_T);
    drive_rx(0, 1'b1, 2 * BIT_CLKS);
    check("glitch_no_valid", 32'(rises[0]), 32'(r0));
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_5a_data", 32'(last_data[0]), 32'h05A);

    ifa.rx_ready = 1'b0;
    send(0, 9'h001, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0);
    send(0, 9'h002, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, BIT_CLKS);
    check("ovr_held_data", 32'(ifa.rx_data), 32'h001);
    check("ovr_held_valid", 32'(ifa.rx_valid), 32'(1));
    check("ovr_pulse_count", 32'(ovr_seen[0]), 32'(1));
    ifa.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_ready_drop", 32'(ifa.rx_valid), 32'(0));

    reset_mid_data(0);
    check("rst_a_no_valid", 32'(ifa.rx_valid), 32'(0));
    send(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, BIT_CLKS);
    check("lit_81_data", 32'(last_data[0]), 32'h081);

    reset_mid_data(1);
    send(1, 9'h015, 5, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, BIT_CLKS);
    check("lit_b15_data", 32'(last_data[1]), 32'h015);
    check("lit_b15_fe", 32'(last_fe[1]), 32'(0));

    repeat (BIT_CLKS) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'(0));
    check("b_queue_drained", 32'(qb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
